// File: rtl/subtract_seq.sv
// subtract_seq: multi-cycle add/subtract unit.
// Wide operands are processed in W-bit chunks, LSB chunk first, through one
// narrow adder. The carry/borrow is chained between chunks. Operations use a
// valid/ready handshake. The unit reports carry/borrow, zero and signed overflow.
module subtract_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_mode,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry,
  output logic         o_valid,
  output logic [N-1:0] o_out,
  output logic         o_carry,
  output logic         o_zero,
  output logic         o_overflow
);

  // Number of compute cycles per operation.
  localparam int CHUNKS = N / W;
  // Chunk index width; at least one bit when there is a single chunk.
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One chunk of the shared adder: returns {carry_out, sum}.
  function automatic logic [W:0] chunk_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    chunk_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow from the operand signs and the result sign.
  // Add overflows when the operands share a sign that the result lost.
  // Subtract overflows when the operand signs differ and the result sign differs from A.
  function automatic logic signed_ovf(
    input logic mode,
    input logic sign_a,
    input logic sign_b,
    input logic sign_r
  );
    if (mode) begin
      signed_ovf = (sign_a == sign_b) && (sign_r != sign_a);
    end else begin
      signed_ovf = (sign_a != sign_b) && (sign_r != sign_a);
    end
  endfunction

  // State and datapath registers.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       a_q, a_d;       // operand A, shifted right one chunk per cycle
  logic [N-1:0]       b_q, b_d;       // operand B, shifted right one chunk per cycle
  logic [N-1:0]       res_q, res_d;   // partial result, filled from the top
  logic               mode_q, mode_d;
  logic               c_q, c_d;       // internal carry; a borrow is kept as inverted carry
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;

  // Output registers; these hold the last completed result.
  logic [N-1:0]       out_q, out_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  // Combinational helpers.
  logic               ready_s;
  logic [W-1:0]       b_eff_s;
  logic [W:0]         sum_s;
  logic [N-1:0]       res_next_s;
  logic               last_s;

  // Ready only when idle and reset is not asserted.
  assign ready_s = (state_q == ST_IDLE) && !i_rst;

  // Chunk datapath: subtraction adds the inverted B chunk.
  // The shift keeps the current chunk at the bottom of the operand registers.
  // The sum enters the partial result from the top.
  always_comb begin
    b_eff_s    = mode_q ? b_q[W-1:0] : ~b_q[W-1:0];
    sum_s      = chunk_add(a_q[W-1:0], b_eff_s, c_q);
    res_next_s = (res_q >> W) | (N'(sum_s[W-1:0]) << (N - W));
    last_s     = (idx_q == LAST_IDX);
  end

  // Next-state and next-datapath logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    mode_d   = mode_q;
    c_d      = c_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    out_d    = out_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_s) begin
          // Capture the operands so that later input changes do not affect this operation.
          a_d      = i_a;
          b_d      = i_b;
          mode_d   = i_mode;
          c_d      = i_mode ? i_carry : ~i_carry;
          sign_a_d = i_a[N-1];
          sign_b_d = i_b[N-1];
          res_d    = {N{1'b0}};
          idx_d    = {IDX_W{1'b0}};
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> W;
        b_d   = b_q >> W;
        res_d = res_next_s;
        c_d   = sum_s[W];
        if (last_s) begin
          // The MSB chunk completes the result; publish it with a one-cycle valid.
          state_d = ST_DONE;
          out_d   = res_next_s;
          carry_d = mode_q ? sum_s[W] : ~sum_s[W];
          zero_d  = (res_next_s == {N{1'b0}});
          ovf_d   = signed_ovf(mode_q, sign_a_q, sign_b_q, sum_s[W-1]);
          valid_d = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      a_q      <= {N{1'b0}};
      b_q      <= {N{1'b0}};
      res_q    <= {N{1'b0}};
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      out_q    <= {N{1'b0}};
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign o_ready    = ready_s;
  assign o_valid    = valid_q;
  assign o_out      = out_q;
  assign o_carry    = carry_q;
  assign o_zero     = zero_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_subtract_seq.sv
// tb_subtract_seq: directed bench for subtract_seq.
// The bench instantiates two units: N=8/W=4 (two chunks) and N=8/W=8 (one chunk).
// A behavioural reference (plain integer arithmetic plus a busy count) predicts
// every output on every cycle. Directed operations also carry hand-computed results.
module tb_subtract_seq;

  logic clk;
  logic rst;

  logic       v0, m0, c0, v1, m1, c1;
  logic [7:0] a0, b0, a1, b1;
  logic       r0, ov0, oc0, oz0, of0;
  logic       r1, ov1, oc1, oz1, of1;
  logic [7:0] oo0, oo1;

  int checks = 0;
  int errors = 0;

  subtract_seq #(.N(8), .W(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(r0), .i_mode(m0),
    .i_a(a0), .i_b(b0), .i_carry(c0), .o_valid(ov0), .o_out(oo0),
    .o_carry(oc0), .o_zero(oz0), .o_overflow(of0)
  );

  subtract_seq #(.N(8), .W(8)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1), .i_mode(m1),
    .i_a(a1), .i_b(b1), .i_carry(c1), .o_valid(ov1), .o_out(oo1),
    .o_carry(oc1), .o_zero(oz1), .o_overflow(of1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array views so that the reference and the compare process can loop over both units.
  logic       iv [2];
  logic       im [2];
  logic       ic [2];
  logic [7:0] ia [2];
  logic [7:0] ib [2];
  logic       o_rdy [2];
  logic       o_vld [2];
  logic       o_c [2];
  logic       o_z [2];
  logic       o_f [2];
  logic [7:0] o_o [2];

  assign iv[0] = v0;  assign iv[1] = v1;
  assign im[0] = m0;  assign im[1] = m1;
  assign ic[0] = c0;  assign ic[1] = c1;
  assign ia[0] = a0;  assign ia[1] = a1;
  assign ib[0] = b0;  assign ib[1] = b1;
  assign o_rdy[0] = r0;  assign o_rdy[1] = r1;
  assign o_vld[0] = ov0; assign o_vld[1] = ov1;
  assign o_c[0] = oc0;   assign o_c[1] = oc1;
  assign o_z[0] = oz0;   assign o_z[1] = oz1;
  assign o_f[0] = of0;   assign o_f[1] = of1;
  assign o_o[0] = oo0;   assign o_o[1] = oo1;

  function automatic int chunks_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Reference result packed as {out[7:0], carry, zero, overflow}.
  function automatic logic [10:0] ref_op(input logic md, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    int ai, bi, cv, r;
    logic [7:0] o;
    logic cy, z, f;
    ai = int'(a);
    bi = int'(b);
    cv = ci ? 1 : 0;
    if (md) begin
      r  = ai + bi + cv;
      cy = (r > 255);
    end else begin
      r  = ai - bi - cv;
      cy = (ai < bi + cv);
    end
    o = r[7:0];
    z = (o == 8'd0);
    if (md) f = (a[7] == b[7]) && (o[7] != a[7]);
    else    f = (a[7] != b[7]) && (o[7] != a[7]);
    return {o, cy, z, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference state. busy counts the edges left until the unit is idle again.
  // When busy is 1, the unit is in its result cycle.
  int          busy [2];
  logic [10:0] pend [2];
  logic [10:0] last [2];
  logic        armed = 1'b0;

  // Reference: accept when idle, then publish the result CHUNKS edges later.
  always @(posedge clk) begin
    if (rst) begin
      armed <= 1'b1;
      for (int d = 0; d < 2; d++) begin
        busy[d] <= 0;
        last[d] <= 11'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d] > 0) begin
          busy[d] <= busy[d] - 1;
          if (busy[d] == 2) last[d] <= pend[d];
        end else if (iv[d]) begin
          pend[d] <= ref_op(im[d], ia[d], ib[d], ic[d]);
          busy[d] <= chunks_of(d) + 1;
        end
      end
    end
  end

  // Compare every output of both units against the reference on each falling edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d o_ready", d), o_rdy[d], (!rst && busy[d] == 0));
        chk($sformatf("dut%0d o_valid", d), o_vld[d], (busy[d] == 1));
        chk($sformatf("dut%0d o_out", d), o_o[d], last[d][10:3]);
        chk($sformatf("dut%0d o_carry", d), o_c[d], last[d][2]);
        chk($sformatf("dut%0d o_zero", d), o_z[d], last[d][1]);
        chk($sformatf("dut%0d o_overflow", d), o_f[d], last[d][0]);
      end
    end
  end

  task automatic drive(input int d, input logic v, input logic md,
                       input logic [7:0] a, input logic [7:0] b, input logic ci);
    if (d == 0) begin
      v0 = v; m0 = md; a0 = a; b0 = b; c0 = ci;
    end else begin
      v1 = v; m1 = md; a1 = a; b1 = b; c1 = ci;
    end
  endtask

  // One operation with hand-computed results and latency.
  // The operands are scrambled right after the accept edge.
  task automatic run_op(input int d, input string name, input logic md,
                        input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] eo, input logic ec, input logic ez,
                        input logic ev, input int elat);
    int lat;
    logic got;
    @(posedge clk); #2;
    drive(d, 1'b1, md, a, b, ci);
    @(posedge clk); #2;
    drive(d, 1'b0, ~md, ~a, a ^ b, ~ci);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = o_vld[d];
    end
    chk({name, " latency"}, lat, elat);
    chk({name, " out"}, o_o[d], eo);
    chk({name, " carry"}, o_c[d], ec);
    chk({name, " zero"}, o_z[d], ez);
    chk({name, " overflow"}, o_f[d], ev);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready0", r0, 1'b0);
    chk("reset ready1", r1, 1'b0);
    chk("reset valid0", ov0, 1'b0);
    chk("reset out0", oo0, 8'd0);
    chk("reset flags0", {oc0, oz0, of0}, 3'b000);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset ready0", r0, 1'b1);
    chk("post-reset ready1", r1, 1'b1);

    // Two-chunk unit.
    run_op(0, "sub 10-5",   1'b0, 8'd10,  8'd5,   1'b0, 8'd5,   1'b0, 1'b0, 1'b0, 3);
    run_op(0, "sub 8-10",   1'b0, 8'd8,   8'd10,  1'b0, 8'hFE,  1'b1, 1'b0, 1'b0, 3);
    run_op(0, "sub 15-8",   1'b0, 8'd15,  8'd8,   1'b0, 8'd7,   1'b0, 1'b0, 1'b0, 3);
    run_op(0, "sub 5-5",    1'b0, 8'd5,   8'd5,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 3);
    run_op(0, "sub 0-0-1",  1'b0, 8'd0,   8'd0,   1'b1, 8'hFF,  1'b1, 1'b0, 1'b0, 3);
    run_op(0, "sub 80-01",  1'b0, 8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b0, 1'b1, 3);
    run_op(0, "add 200+100",1'b1, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0, 3);
    run_op(0, "add 7F+01",  1'b1, 8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b0, 1'b1, 3);
    run_op(0, "add FF+0+1", 1'b1, 8'hFF,  8'h00,  1'b1, 8'h00,  1'b1, 1'b1, 1'b0, 3);

    // Single-chunk unit.
    run_op(1, "w8 sub 10-5", 1'b0, 8'd10, 8'd5,  1'b0, 8'd5,  1'b0, 1'b0, 1'b0, 2);
    run_op(1, "w8 sub 8-10", 1'b0, 8'd8,  8'd10, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 2);
    run_op(1, "w8 sub 15-8", 1'b0, 8'd15, 8'd8,  1'b0, 8'd7,  1'b0, 1'b0, 1'b0, 2);
    run_op(1, "w8 sub 5-5",  1'b0, 8'd5,  8'd5,  1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 2);

    // Hold valid high with operands that change every cycle on both units.
    @(posedge clk); #2;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      drive(1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      @(posedge clk); #2;
    end
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (5) @(posedge clk);

    // Leave a known nonzero result, then reset one cycle after an accept.
    run_op(0, "pre-rst add", 1'b1, 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 3);
    @(posedge clk); #2;
    drive(0, 1'b1, 1'b0, 8'd100, 8'd1, 1'b0);
    @(posedge clk); #2;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst-high ready1", r1, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort out", oo0, 8'd0);
    chk("abort flags", {oc0, oz0, of0}, 3'b000);
    chk("abort ready", r0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no valid", ov0, 1'b0);
    end
    run_op(0, "post-rst sub", 1'b0, 8'd20, 8'd7, 1'b0, 8'd13, 1'b0, 1'b0, 1'b0, 3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Stop a hung run after printing a failure.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
